// File: rtl/demux_sched16_if.sv
// demux_sched16_if
// Bundles the request/grant signals of the round-robin demux scheduler.
//   en   : controller enable, driven by the requesting side
//   req  : 16 request lines, bit i belongs to requester i
//   done : current grantee releases the path
//   S    : demux select, index of the current grantee
//   E    : demux enable, high only while a grant is active
//   Y    : one-hot grant vector, Y[S] = E
//   busy : scheduler is arbitrating, granting or releasing
//   tmo  : one-cycle pulse when a grant ended purely by timeout
// The master modport is the requesting side; the slave modport is the scheduler.
interface demux_sched16_if;
  logic        en;
  logic [15:0] req;
  logic        done;
  logic [3:0]  S;
  logic        E;
  logic [15:0] Y;
  logic        busy;
  logic        tmo;

  modport master (
    output en, req, done,
    input  S, E, Y, busy, tmo
  );

  modport slave (
    input  en, req, done,
    output S, E, Y, busy, tmo
  );
endinterface

// File: rtl/demux_sched16.sv
// demux_sched16
// Round-robin scheduler that steers one 16-way demux path to a single
// requester at a time, with a bounded grant dwell.
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : demux_sched16_if.slave (en/req/done in, S/E/Y/busy/tmo out)
// Every output is a register computed from the next-state logic, so the
// outputs always line up with the state they describe and no input reaches
// an output combinationally.
module demux_sched16 #(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  demux_sched16_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, RELEASE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic        e_q, e_nxt;
  logic [15:0] y_q, y_nxt;
  logic        busy_q, busy_nxt;
  logic        tmo_q, tmo_nxt;

  logic [3:0]  win_idx;
  logic        win_found;
  logic [3:0]  scan_idx;

  logic        exit_done, exit_drop, exit_en, exit_tmo, exit_any;

  assign bus.S    = sel_q;
  assign bus.E    = e_q;
  assign bus.Y    = y_q;
  assign bus.busy = busy_q;
  assign bus.tmo  = tmo_q;

  // Round-robin search starting just after the last served index; the
  // offset 16 wraps to the pointer itself, so the previous grantee is the
  // very last candidate.
  always_comb begin
    win_idx   = ptr;
    win_found = 1'b0;
    scan_idx  = ptr;
    for (int k = 1; k <= 16; k++) begin
      scan_idx = ptr + 4'(k);
      if (!win_found && bus.req[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Grant exit causes; done and a dropped request outrank the timeout so
  // tmo only flags grants that were cut short purely by the dwell limit.
  always_comb begin
    exit_done = bus.done;
    exit_drop = !bus.req[sel_q];
    exit_en   = !bus.en;
    exit_tmo  = (cnt == LAST_CNT);
    exit_any  = exit_done || exit_drop || exit_en || exit_tmo;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output logic; outputs are derived from the state
  // being entered so they register together with it.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && (bus.req != 16'h0000)) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        cnt_nxt = 8'h00;
        if (bus.en && win_found) begin
          sel_nxt   = win_idx;
          state_nxt = GRANT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (exit_any) begin
          state_nxt = RELEASE;
          tmo_nxt   = exit_tmo && !exit_done && !exit_drop && !exit_en;
        end else begin
          cnt_nxt = cnt + 8'h01;
        end
      end
      RELEASE: begin
        ptr_nxt = sel_q;
        cnt_nxt = 8'h00;
        if (bus.en && (bus.req != 16'h0000)) begin
          state_nxt = ARB;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    e_nxt    = (state_nxt == GRANT);
    y_nxt    = e_nxt ? (16'h0001 << sel_nxt) : 16'h0000;
    busy_nxt = (state_nxt != IDLE);
  end

  // Datapath and output registers. The pointer resets to 15 so the first
  // search after reset begins at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 4'hF;
      cnt    <= 8'h00;
      sel_q  <= 4'h0;
      e_q    <= 1'b0;
      y_q    <= 16'h0000;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      sel_q  <= sel_nxt;
      e_q    <= e_nxt;
      y_q    <= y_nxt;
      busy_q <= busy_nxt;
      tmo_q  <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_demux_sched16.sv
// tb_demux_sched16
// Directed scenarios for demux_sched16 with TIMEOUT=8. Inputs change and
// outputs are sampled on the falling clock edge, half a period away from
// the rising edge where the scheduler updates.
module tb_demux_sched16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  demux_sched16_if bus_if ();

  demux_sched16 #(.TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one full cycle; returns just after the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Tick until E is high or the bound runs out; n is the number of ticks.
  task automatic wait_e_high(input int bound, output int n);
    n = 0;
    while (bus_if.E !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Pulse reset for one cycle with all inputs quiet.
  task automatic reset_dut();
    tick();
    rst         = 1'b1;
    bus_if.en   = 1'b0;
    bus_if.req  = 16'h0000;
    bus_if.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus_if.en   = 1'b0;
    bus_if.req  = 16'h0000;
    bus_if.done = 1'b0;
    tick();
    vectors++;
    if (bus_if.S !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_S: got %0h want 0", bus_if.S); end
    vectors++;
    if (bus_if.E !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_E: got %0b want 0", bus_if.E); end
    vectors++;
    if (bus_if.Y !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_Y: got %h want 0000", bus_if.Y); end
    vectors++;
    if (bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", bus_if.busy); end
    vectors++;
    if (bus_if.tmo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tmo: got %0b want 0", bus_if.tmo); end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    int hi;
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h0001;
    tick();
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_arb: E=%0b busy=%0b want E=0 busy=1", bus_if.E, bus_if.busy); end
    wait_e_high(10, n);
    vectors++;
    if (n != 1) begin miscompares++; $display("[TB] FAIL tmo_rise: ticks %0d want 1", n); end
    vectors++;
    if (bus_if.S !== 4'h0 || bus_if.Y !== 16'h0001) begin miscompares++; $display("[TB] FAIL tmo_grant: S=%0d Y=%h want S=0 Y=0001", bus_if.S, bus_if.Y); end
    hi = 1;
    tick();
    while (bus_if.E === 1'b1 && hi < 20) begin
      hi++;
      tick();
    end
    vectors++;
    if (hi != 8) begin miscompares++; $display("[TB] FAIL tmo_dwell: E high %0d cycles want 8", hi); end
    vectors++;
    if (bus_if.tmo !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_pulse: tmo=%0b want 1", bus_if.tmo); end
    tick();
    vectors++;
    if (bus_if.tmo !== 1'b0 || bus_if.E !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_gap: tmo=%0b E=%0b want 0 0", bus_if.tmo, bus_if.E); end
    tick();
    vectors++;
    if (bus_if.E !== 1'b1 || bus_if.S !== 4'h0) begin miscompares++; $display("[TB] FAIL tmo_regrant: E=%0b S=%0d want E=1 S=0", bus_if.E, bus_if.S); end
  endtask

  task automatic test_round_robin();
    int          n;
    int          exp_s [4];
    logic [15:0] y_exp;
    exp_s = '{0, 7, 15, 0};
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h8081;
    for (int g = 0; g < 4; g++) begin
      wait_e_high(10, n);
      vectors++;
      if (n != 2) begin miscompares++; $display("[TB] FAIL rr_gap%0d: ticks %0d want 2", g, n); end
      y_exp = 16'h0001 << exp_s[g];
      vectors++;
      if (bus_if.S !== 4'(exp_s[g]) || bus_if.Y !== y_exp) begin miscompares++; $display("[TB] FAIL rr_grant%0d: S=%0d Y=%h want S=%0d Y=%h", g, bus_if.S, bus_if.Y, exp_s[g], y_exp); end
      bus_if.done = 1'b1;
      tick();
      bus_if.done = 1'b0;
      vectors++;
      if (bus_if.E !== 1'b0 || bus_if.tmo !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_release%0d: E=%0b tmo=%0b want 0 0", g, bus_if.E, bus_if.tmo); end
    end
  endtask

  task automatic test_drop_req();
    int n;
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h0020;
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'h5) begin miscompares++; $display("[TB] FAIL drop_grant: ticks %0d S=%0d want 2 5", n, bus_if.S); end
    bus_if.req = 16'h0021;
    tick();
    vectors++;
    if (bus_if.E !== 1'b1 || bus_if.S !== 4'h5) begin miscompares++; $display("[TB] FAIL drop_other_req: E=%0b S=%0d want 1 5", bus_if.E, bus_if.S); end
    bus_if.req = 16'h0110;
    tick();
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.tmo !== 1'b0 || bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_release: E=%0b tmo=%0b busy=%0b want 0 0 1", bus_if.E, bus_if.tmo, bus_if.busy); end
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'h8) begin miscompares++; $display("[TB] FAIL drop_next_search: ticks %0d S=%0d want 2 8", n, bus_if.S); end
  endtask

  task automatic test_simul_exit();
    int n;
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h0001;
    wait_e_high(10, n);
    repeat (7) tick();
    vectors++;
    if (bus_if.E !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_dwell: E=%0b want 1", bus_if.E); end
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.tmo !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_release: E=%0b tmo=%0b want 0 0", bus_if.E, bus_if.tmo); end
    tick();
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.tmo !== 1'b0 || bus_if.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_arb: E=%0b tmo=%0b busy=%0b want 0 0 1", bus_if.E, bus_if.tmo, bus_if.busy); end
    tick();
    vectors++;
    if (bus_if.E !== 1'b1 || bus_if.S !== 4'h0) begin miscompares++; $display("[TB] FAIL simul_regrant: E=%0b S=%0d want 1 0", bus_if.E, bus_if.S); end
  endtask

  task automatic test_wrap();
    int n;
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h8000;
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'hF) begin miscompares++; $display("[TB] FAIL wrap_first: ticks %0d S=%0d want 2 15", n, bus_if.S); end
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'hF || bus_if.Y !== 16'h8000) begin miscompares++; $display("[TB] FAIL wrap_regrant: ticks %0d S=%0d Y=%h want 2 15 8000", n, bus_if.S, bus_if.Y); end
  endtask

  task automatic test_reset_mid_grant();
    int n;
    reset_dut();
    bus_if.en  = 1'b1;
    bus_if.req = 16'h0200;
    wait_e_high(10, n);
    tick();
    vectors++;
    if (bus_if.S !== 4'h9 || bus_if.E !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_grant: S=%0d E=%0b want 9 1", bus_if.S, bus_if.E); end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.Y !== 16'h0000 || bus_if.S !== 4'h0 || bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_async: E=%0b Y=%h S=%0d busy=%0b want 0 0000 0 0", bus_if.E, bus_if.Y, bus_if.S, bus_if.busy); end
    tick();
    rst = 1'b0;
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'h9 || bus_if.Y !== 16'h0200) begin miscompares++; $display("[TB] FAIL rstmid_regrant: ticks %0d S=%0d Y=%h want 2 9 0200", n, bus_if.S, bus_if.Y); end
  endtask

  task automatic test_enable();
    int n;
    reset_dut();
    bus_if.en  = 1'b0;
    bus_if.req = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({bus_if.E, bus_if.busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL en_low_idle%0d: E=%0b busy=%0b want 0 0", i, bus_if.E, bus_if.busy); end
    end
    bus_if.en = 1'b1;
    wait_e_high(10, n);
    vectors++;
    if (n != 2 || bus_if.S !== 4'h0) begin miscompares++; $display("[TB] FAIL en_grant: ticks %0d S=%0d want 2 0", n, bus_if.S); end
    bus_if.en = 1'b0;
    tick();
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.tmo !== 1'b0) begin miscompares++; $display("[TB] FAIL en_drop_release: E=%0b busy=%0b tmo=%0b want 0 1 0", bus_if.E, bus_if.busy, bus_if.tmo); end
    tick();
    vectors++;
    if (bus_if.E !== 1'b0 || bus_if.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL en_drop_idle: E=%0b busy=%0b want 0 0", bus_if.E, bus_if.busy); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus_if.en   = 1'b0;
    bus_if.req  = 16'h0000;
    bus_if.done = 1'b0;
    $display("[TB] demux_sched16 directed scenarios");
    test_reset();
    test_timeout();
    test_round_robin();
    test_drop_req();
    test_simul_exit();
    test_wrap();
    test_reset_mid_grant();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_sched16.md
DEMUX_SCHED16 -- requirements
Module: demux_sched16

Interface
REQ-001 Parameter: TIMEOUT, default 8, maximum GRANT dwell in cycles, legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  controller enable; low stops new grants.
REQ-005 Port: req  input  16  request lines; bit i = requester i wants the demux path.
REQ-006 Port: done  input  1  the current grantee releases the path.
REQ-007 Port: S  output  4  demux select; index of the current grantee.
REQ-008 Port: E  output  1  demux enable; high only in GRANT.
REQ-009 Port: Y  output  16  one-hot grant; Y[S]=E, all other bits 0.
REQ-010 Port: busy  output  1  high in ARB, GRANT and RELEASE.
REQ-011 Port: tmo  output  1  one-cycle pulse when a grant ends by timeout.
REQ-012 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-013 Clock and reset SHALL be exactly as follows: one clock; reset is asynchronous and active-high.

Function
REQ-014 The FSM SHALL have four states: IDLE, ARB, GRANT and RELEASE.
REQ-015 IDLE: E=0 and busy=0; if en=1 and req!=0 at an edge, the next state SHALL be ARB, otherwise it SHALL stay IDLE.
REQ-016 ARB: the block SHALL select the lowest index i, searched in order ptr+1, ptr+2 ... wrapping mod 16, with req[i]=1.
REQ-017 ARB: the block SHALL load S=i and go to GRANT, so E rises on the second edge after req is sampled in IDLE.
REQ-018 ARB: if req==0 or en==0 on the ARB edge, the block SHALL return to IDLE with S unchanged and E=0.
REQ-019 GRANT: S SHALL hold stable, E=1 and Y=onehot(S), and a dwell counter SHALL count from 0, once per cycle.
REQ-020 GRANT exit: the block SHALL go to RELEASE at the first edge where done=1, req[S]=0, en=0, or the counter equals TIMEOUT-1.
REQ-021 Simultaneous exit causes SHALL produce a single RELEASE.
REQ-022 tmo SHALL pulse only when the timeout is the sole exit cause, i.e. done=1 or req[S]=0 takes priority over tmo.
REQ-023 RELEASE: E=0 and Y=0 for exactly one dead cycle, ptr:=S, and the counter SHALL be cleared.
REQ-024 RELEASE: the next state SHALL be ARB if en=1 and req!=0, else IDLE.
REQ-025 Back-to-back grants SHALL therefore have at least 2 cycles between them with E=0 (RELEASE, then ARB).
REQ-026 Round-robin fairness: a requester holding req continuously SHALL be granted within 15 grants.
REQ-027 A requester just served SHALL have the lowest priority in the next ARB.
REQ-028 The pointer SHALL wrap: ptr=15 searches 0,1,...,15, and ptr=15 with only req[15]=1 SHALL re-grant 15.
REQ-029 The timeout counter width SHALL be 8 bits; TIMEOUT=1 SHALL yield exactly one GRANT cycle.
REQ-030 req changes during GRANT for indices other than S SHALL NOT affect S or E.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, S=0, E=0, Y=0, busy=0, tmo=0, counter=0, ptr=15.
REQ-032 Reset asserted mid-GRANT SHALL drop E and Y to 0 immediately without waiting for a clock edge.
REQ-033 After reset, the first arbitration SHALL start its search at index 0.
REQ-034 Release of rst SHALL take effect at the next edge; the first possible E=1 is 2 edges after req is sampled.

Verification
REQ-035 Scenario: after reset, en=1, req=16'h0001 held, done=0, TIMEOUT=8 -> E rises on edge 2, S=0, Y=16'h0001, E high 8 cycles, then tmo=1 for one cycle, E=0 for 2 cycles, regrant of S=0.
REQ-036 Scenario: req=16'h8081 held, done pulsed 1 cycle into each grant -> grant order S=0,7,15,0, each with a 2-cycle E=0 gap.
REQ-037 Scenario: in GRANT with S=5, drop req[5] -> RELEASE on the next edge, tmo stays 0, ptr=5, and the next search starts at 6.
REQ-038 Scenario: done=1 on the same edge the counter hits TIMEOUT-1 -> single RELEASE, tmo=0.
REQ-039 Scenario: assert rst mid-GRANT with S=9 -> E=0, Y=0, S=0 asynchronously; after release, req=16'h0200 yields S=9 again on edge 2.
REQ-040 Scenario: en=0 with req=16'hFFFF -> stays IDLE, E=0, busy=0 indefinitely; dropping en during GRANT -> RELEASE then IDLE.
